// File: rtl/kugelblitz_rx_inspect.sv
// kugelblitz_rx_inspect: passive tap on a 512-bit RX AXI-stream. It takes the byte at a
// programmable frame offset from every enabled frame and queues it, tagged with a 16-bit
// frame sequence number, in a small FIFO that software drains over AXI-lite.
module kugelblitz_rx_inspect #(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 1,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int OFFSET_WIDTH    = 12,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready
);

    localparam int LANE_BITS  = $clog2(KEEP_WIDTH);
    localparam int BEAT_BITS  = OFFSET_WIDTH - LANE_BITS;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS   = PTR_BITS + 1;
    localparam int ENTRY_BITS = 24;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_OFFSET = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_FRAMES = 3'd4;
    localparam logic [2:0] REG_MISSES = 3'd5;

    // Control / status state
    logic                       enable_reg;
    logic [OFFSET_WIDTH-1:0]    offset_reg;
    logic                       clear_pend_reg;
    logic                       bvalid_reg;
    logic                       rvalid_reg;
    logic [AXIL_DATA_WIDTH-1:0] rdata_reg;
    logic [31:0]                frames_reg;
    logic [31:0]                misses_reg;
    logic [15:0]                seq_reg;

    // Per-frame capture state
    logic [BEAT_BITS-1:0]       beat_idx_reg;
    logic                       frame_en_reg;
    logic [OFFSET_WIDTH-1:0]    frame_off_reg;
    logic                       pushed_reg;

    // Capture FIFO
    logic [ENTRY_BITS-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]        wr_ptr_reg;
    logic [PTR_BITS-1:0]        rd_ptr_reg;
    logic [LVL_BITS-1:0]        level_reg;
    logic                       overflow_reg;

    // Combinational helpers
    logic [7:0]                 lane_bytes [KEEP_WIDTH];
    logic                       first_beat;
    logic                       cur_en;
    logic [OFFSET_WIDTH-1:0]    cur_off;
    logic                       cur_pushed;
    logic [LANE_BITS-1:0]       cur_lane;
    logic [BEAT_BITS-1:0]       cur_beat;
    logic                       push;
    logic                       push_ok;
    logic                       drop;
    logic                       pop;
    logic                       frame_end;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       wr_fire;
    logic                       rd_fire;
    logic [2:0]                 wr_sel;
    logic [2:0]                 rd_sel;
    logic [AXIL_DATA_WIDTH-1:0] rd_word;
    logic                       unused_inputs;

    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
        assign lane_bytes[gi] = s_axis_tdata[gi*8 +: 8];
    end

    // On the first beat the live registers apply; later beats use the values latched then.
    assign first_beat = (beat_idx_reg == '0);
    assign cur_en     = first_beat ? enable_reg : frame_en_reg;
    assign cur_off    = first_beat ? offset_reg : frame_off_reg;
    assign cur_pushed = first_beat ? 1'b0 : pushed_reg;
    assign cur_lane   = cur_off[LANE_BITS-1:0];
    assign cur_beat   = cur_off[OFFSET_WIDTH-1:LANE_BITS];

    assign push = s_axis_tvalid && cur_en && !cur_pushed &&
                  (beat_idx_reg == cur_beat) && s_axis_tkeep[cur_lane];
    assign frame_end = s_axis_tvalid && s_axis_tlast && cur_en;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == LVL_BITS'(FIFO_DEPTH));

    assign wr_fire = s_axil_awvalid && s_axil_wvalid && !bvalid_reg;
    assign rd_fire = s_axil_arvalid && !rvalid_reg;
    assign wr_sel  = s_axil_awaddr[4:2];
    assign rd_sel  = s_axil_araddr[4:2];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
    assign pop     = rd_fire && (rd_sel == REG_DATA) && !fifo_empty;
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    assign s_axil_awready = wr_fire;
    assign s_axil_wready  = wr_fire;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = rd_fire;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = 2'b00;

    assign unused_inputs = ^{s_axis_tuser, s_axil_awprot, s_axil_arprot, s_axil_wstrb,
                             s_axil_awaddr, s_axil_araddr, s_axil_wdata};

    // AXI-lite write side: register updates, clear request and write response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_reg     <= 1'b0;
            offset_reg     <= '0;
            clear_pend_reg <= 1'b0;
            bvalid_reg     <= 1'b0;
        end else begin
            clear_pend_reg <= wr_fire && (wr_sel == REG_CTRL) && s_axil_wdata[1];
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                case (wr_sel)
                    REG_CTRL:   enable_reg <= s_axil_wdata[0];
                    REG_OFFSET: offset_reg <= s_axil_wdata[OFFSET_WIDTH-1:0];
                    default:    ;
                endcase
            end else if (s_axil_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read-data mux for the addressed register
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            REG_CTRL:   rd_word[0] = enable_reg;
            REG_OFFSET: rd_word[OFFSET_WIDTH-1:0] = offset_reg;
            REG_STATUS: begin
                rd_word[LVL_BITS-1:0] = level_reg;
                rd_word[16]           = fifo_empty;
                rd_word[17]           = fifo_full;
                rd_word[18]           = overflow_reg;
            end
            REG_DATA: begin
                if (!fifo_empty) begin
                    rd_word = {1'b1, 7'b0, fifo_mem[rd_ptr_reg]};
                end
            end
            REG_FRAMES: rd_word = frames_reg;
            REG_MISSES: rd_word = misses_reg;
            default:    ;
        endcase
    end

    // AXI-lite read side: capture data on acceptance, hold it until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (rd_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_word;
        end else if (s_axil_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    // Frame tracking: saturating beat index plus the settings latched on the first beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx_reg  <= '0;
            frame_en_reg  <= 1'b0;
            frame_off_reg <= '0;
            pushed_reg    <= 1'b0;
        end else if (s_axis_tvalid) begin
            if (first_beat) begin
                frame_en_reg  <= enable_reg;
                frame_off_reg <= offset_reg;
            end
            pushed_reg <= cur_pushed || push;
            if (s_axis_tlast) begin
                beat_idx_reg <= '0;
            end else if (beat_idx_reg != '1) begin
                beat_idx_reg <= beat_idx_reg + 1'b1;
            end
        end
    end

    // Capture FIFO storage (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (push_ok && !clear_pend_reg) begin
            fifo_mem[wr_ptr_reg] <= {seq_reg, lane_bytes[cur_lane]};
        end
    end

    // FIFO pointers, level and sticky overflow; clear beats any same-cycle push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear_pend_reg) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push_ok) begin
                level_reg <= level_reg - 1'b1;
            end
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // Frame / miss counters and the sequence tag, advanced at the end of enabled frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_reg <= '0;
            misses_reg <= '0;
            seq_reg    <= '0;
        end else if (clear_pend_reg) begin
            frames_reg <= '0;
            misses_reg <= '0;
            seq_reg    <= '0;
        end else if (frame_end) begin
            frames_reg <= frames_reg + 1'b1;
            seq_reg    <= seq_reg + 1'b1;
            if (!cur_pushed && !push) misses_reg <= misses_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_kugelblitz_rx_inspect.sv
// Directed bench for kugelblitz_rx_inspect: a table of register writes, stream beats and
// register reads with hand-computed expectations, followed by hand-written sequences for
// FIFO overflow, simultaneous push/pop, clear and mid-frame reset.
`timescale 1ns/1ps
module tb_kugelblitz_rx_inspect;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_OFFSET = 32'h04;
    localparam logic [31:0] A_STATUS = 32'h08;
    localparam logic [31:0] A_DATA   = 32'h0C;
    localparam logic [31:0] A_FRAMES = 32'h10;
    localparam logic [31:0] A_MISSES = 32'h14;
    localparam logic [31:0] A_OTHER  = 32'h18;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_BEAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid;
    logic         tlast;
    logic [0:0]   tuser;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    kugelblitz_rx_inspect dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tvalid  (tvalid),
        .s_axis_tlast   (tlast),
        .s_axis_tuser   (tuser),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    typedef struct {
        int          op;
        logic [31:0] addr;   // register address, or for beats: [5:0] lane, [8] last, [9] keep off
        logic [31:0] data;   // write data, or for beats: [7:0] byte placed in the lane
        logic [31:0] exp;    // expected read value
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: handshake timed out, got no response, expected one within 20 cycles", name);
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(awready && wready)) timeout("axil_write_accept");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) timeout("axil_write_bvalid");
        @(posedge clk);
        #1;
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!arready) timeout("axil_read_accept");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) timeout("axil_read_rvalid");
        data = rdata;
        @(posedge clk);
        #1;
    endtask

    // Background byte i = i + 0x40 so a wrong lane gives a distinguishable value
    task automatic set_beat(input int lane, input logic [7:0] val, input logic last, input logic keep_off);
        for (int i = 0; i < 64; i++) tdata[i*8 +: 8] = 8'(i + 64);
        tdata[lane*8 +: 8] = val;
        tkeep = '1;
        if (keep_off) tkeep[lane] = 1'b0;
        tvalid = 1'b1;
        tlast  = last;
    endtask

    task automatic send_beat(input int lane, input logic [7:0] val, input logic last, input logic keep_off);
        @(negedge clk);
        set_beat(lane, val, last, keep_off);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        axil_read(addr, got);
        check(name, got, exp);
    endtask

    function automatic void add(input int op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.op   = op;
        v.addr = addr;
        v.data = data;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] got;

        rst     = 1'b1;
        tdata   = '0;
        tkeep   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tuser   = '0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = 4'hF;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", {31'b0, bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {28'b0, bresp, rresp}, 32'h0);
        rst = 1'b0;

        // Reset values
        add(OP_RD, A_CTRL,   0, 32'h0000_0000, "reset_ctrl");
        add(OP_RD, A_OFFSET, 0, 32'h0000_0000, "reset_offset");
        add(OP_RD, A_STATUS, 0, 32'h0001_0000, "reset_status");
        add(OP_RD, A_FRAMES, 0, 32'h0000_0000, "reset_frames");
        add(OP_RD, A_MISSES, 0, 32'h0000_0000, "reset_misses");
        add(OP_RD, A_DATA,   0, 32'h0000_0000, "reset_data");
        // 1-beat frame, offset 5
        add(OP_WR, A_OFFSET, 32'h05, 0, "wr_offset5");
        add(OP_WR, A_CTRL,   32'h01, 0, "wr_enable");
        add(OP_BEAT, 32'h105, 32'h3C, 0, "beat_t1");
        add(OP_RD, A_STATUS, 0, 32'h0000_0001, "t1_status_lvl1");
        add(OP_RD, A_DATA,   0, 32'h8000_003C, "t1_data");
        add(OP_RD, A_STATUS, 0, 32'h0001_0000, "t1_status_lvl0");
        add(OP_RD, A_FRAMES, 0, 32'h0000_0001, "t1_frames");
        add(OP_RD, A_CTRL,   0, 32'h0000_0001, "t1_ctrl");
        add(OP_RD, A_OFFSET, 0, 32'h0000_0005, "t1_offset");
        // 3-beat frame, offset 0x7F -> beat 1 lane 63, seq 1
        add(OP_WR, A_OFFSET, 32'h7F, 0, "wr_offset7f");
        add(OP_BEAT, 32'h03F, 32'h11, 0, "beat_t2_b0");
        add(OP_BEAT, 32'h03F, 32'hA5, 0, "beat_t2_b1");
        add(OP_BEAT, 32'h100, 32'h00, 0, "beat_t2_b2");
        add(OP_RD, A_DATA,   0, 32'h8000_01A5, "t2_data");
        add(OP_RD, A_FRAMES, 0, 32'h0000_0002, "t2_frames");
        // Frame too short for the offset -> miss
        add(OP_BEAT, 32'h13F, 32'h22, 0, "beat_t2_short");
        add(OP_RD, A_MISSES, 0, 32'h0000_0001, "t2_misses");
        add(OP_RD, A_STATUS, 0, 32'h0001_0000, "t2_status_empty");
        // Offset lane with tkeep=0 -> miss
        add(OP_WR, A_OFFSET, 32'h05, 0, "wr_offset5b");
        add(OP_BEAT, 32'h305, 32'h33, 0, "beat_keep_off");
        add(OP_RD, A_MISSES, 0, 32'h0000_0002, "keep_off_misses");
        add(OP_RD, A_FRAMES, 0, 32'h0000_0004, "keep_off_frames");
        // Disabled frame is ignored entirely
        add(OP_WR, A_CTRL,   32'h00, 0, "wr_disable");
        add(OP_BEAT, 32'h105, 32'h99, 0, "beat_disabled");
        add(OP_RD, A_FRAMES, 0, 32'h0000_0004, "disabled_frames");
        add(OP_RD, A_STATUS, 0, 32'h0001_0000, "disabled_status");
        add(OP_WR, A_CTRL,   32'h01, 0, "wr_reenable");
        // Unmapped address
        add(OP_WR, A_OTHER,  32'hFFFF_FFFF, 0, "wr_other");
        add(OP_RD, A_OTHER,  0, 32'h0000_0000, "rd_other");
        add(OP_RD, A_CTRL,   0, 32'h0000_0001, "ctrl_after_other");

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:   axil_write(vecs[i].addr, vecs[i].data);
                OP_BEAT: send_beat(int'(vecs[i].addr[5:0]), vecs[i].data[7:0],
                                   vecs[i].addr[8], vecs[i].addr[9]);
                default: begin
                    axil_read(vecs[i].addr, got);
                    check(vecs[i].name, got, vecs[i].exp);
                end
            endcase
        end

        // Overflow: 18 frames into a 16-deep FIFO
        axil_write(A_CTRL, 32'h3);
        rd_check("clr_frames", A_FRAMES, 32'h0);
        rd_check("clr_misses", A_MISSES, 32'h0);
        for (int i = 0; i < 18; i++) send_beat(5, 8'(8'h80 + i), 1'b1, 1'b0);
        rd_check("ovf_status", A_STATUS, 32'h0006_0010);
        rd_check("ovf_frames", A_FRAMES, 32'd18);
        for (int i = 0; i < 16; i++) begin
            axil_read(A_DATA, got);
            check($sformatf("ovf_data%0d", i), got, 32'h8000_0000 | (32'(i) << 8) | 32'(8'h80 + i));
        end
        rd_check("ovf_status_drained", A_STATUS, 32'h0005_0000);

        // Simultaneous push and pop at level 3
        axil_write(A_CTRL, 32'h3);
        rd_check("clr2_status", A_STATUS, 32'h0001_0000);
        for (int i = 0; i < 3; i++) send_beat(5, 8'(8'h10 + i), 1'b1, 1'b0);
        rd_check("pp_status_pre", A_STATUS, 32'h0000_0003);
        @(negedge clk);
        set_beat(5, 8'h13, 1'b1, 1'b0);
        araddr  = A_DATA;
        arvalid = 1'b1;
        #1;
        check("pp_arready", {31'b0, arready}, 32'h1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        @(negedge clk);
        check("pp_rvalid", {31'b0, rvalid}, 32'h1);
        check("pp_data", rdata, 32'h8000_0010);
        rd_check("pp_status_post", A_STATUS, 32'h0000_0003);
        rd_check("pp_data1", A_DATA, 32'h8000_0111);
        rd_check("pp_data2", A_DATA, 32'h8000_0212);
        rd_check("pp_data3", A_DATA, 32'h8000_0313);

        // Empty read, then clear
        rd_check("empty_data", A_DATA, 32'h0);
        rd_check("empty_status", A_STATUS, 32'h0001_0000);
        send_beat(5, 8'h44, 1'b1, 1'b1);
        rd_check("pre_clr_frames", A_FRAMES, 32'd5);
        rd_check("pre_clr_misses", A_MISSES, 32'd1);
        axil_write(A_CTRL, 32'h3);
        rd_check("post_clr_frames", A_FRAMES, 32'h0);
        rd_check("post_clr_misses", A_MISSES, 32'h0);
        rd_check("post_clr_status", A_STATUS, 32'h0001_0000);
        rd_check("post_clr_ctrl", A_CTRL, 32'h1);
        send_beat(5, 8'h77, 1'b1, 1'b0);
        rd_check("post_clr_seq0", A_DATA, 32'h8000_0077);

        // Reset in the middle of beat 1 of a 3-beat frame
        axil_write(A_OFFSET, 32'h45);
        send_beat(5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        set_beat(5, 8'hEE, 1'b0, 1'b0);
        #2;
        rst    = 1'b1;
        tvalid = 1'b0;
        #2;
        rst = 1'b0;
        rd_check("rst6_ctrl", A_CTRL, 32'h0);
        rd_check("rst6_offset", A_OFFSET, 32'h0);
        rd_check("rst6_status", A_STATUS, 32'h0001_0000);
        rd_check("rst6_frames", A_FRAMES, 32'h0);
        axil_write(A_CTRL, 32'h1);
        send_beat(0, 8'h5A, 1'b1, 1'b0);
        rd_check("rst6_capture", A_DATA, 32'h8000_005A);
        rd_check("rst6_frames1", A_FRAMES, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
